// File: rtl/viterbi_pkg.sv
// Shared definitions for the convolutional encoder and the Viterbi decoder datapath:
// default code parameters, the encoder state type and the parity helper.
package viterbi_pkg;

    localparam int unsigned K_MAX = 16;
    localparam int unsigned K_DEF = 3;

    localparam logic [K_MAX-1:0] G0_DEF = 16'o7;
    localparam logic [K_MAX-1:0] G1_DEF = 16'o5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_FLUSH,
        ST_DONE
    } enc_state_t;

    // Operands are zero-extended to K_MAX so one function serves any K.
    function automatic logic parity(input logic [K_MAX-1:0] v, input logic [K_MAX-1:0] g);
        return ^(v & g);
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational rate-1/2 symbol generation and shift-register update for one input bit.
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter int unsigned     K  = K_DEF,
    parameter logic [K-1:0]    G0 = G0_DEF[K-1:0],
    parameter logic [K-1:0]    G1 = G1_DEF[K-1:0]
) (
    input  logic         din,
    input  logic [K-2:0] sr,
    output logic [1:0]   sym,
    output logic [K-2:0] sr_next
);

    localparam logic [K_MAX-1:0] G0_EXT = K_MAX'(G0);
    localparam logic [K_MAX-1:0] G1_EXT = K_MAX'(G1);

    logic [K_MAX-1:0] v;

    assign v   = K_MAX'({din, sr});
    assign sym = {parity(v, G0_EXT), parity(v, G1_EXT)};

    // Newest bit enters at the top; a single-bit register for K=2 has nothing to shift.
    generate
        if (K == 2) begin : g_sr_k2
            assign sr_next = din;
        end else begin : g_sr_kn
            assign sr_next = {din, sr[K-2:1]};
        end
    endgenerate

endmodule

// File: rtl/conv_enc_frame.sv
// Framed rate-1/2 convolutional encoder: one symbol per accepted bit, then K-1 zero
// tail symbols so each frame ends in state 0. A global en stalls everything.
module conv_enc_frame
    import viterbi_pkg::*;
#(
    parameter int unsigned  K         = K_DEF,
    parameter logic [K-1:0] G0        = G0_DEF[K-1:0],
    parameter logic [K-1:0] G1        = G1_DEF[K-1:0],
    parameter int unsigned  FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] dout,
    output logic       dout_valid,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
    localparam int unsigned FL_W  = (K > 2) ? $clog2(K - 1) : 1;

    enc_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [FL_W-1:0]  flush_cnt, flush_cnt_n;
    logic [K-2:0]     sr, sr_n;
    logic [1:0]       dout_n;
    logic             dout_valid_n;
    logic             busy_n;
    logic             frame_done_n;

    logic             enc_bit;
    logic [1:0]       sym;
    logic [K-2:0]     sr_next;

    assign din_ready = (state == ST_DATA) && en;
    assign enc_bit   = (state == ST_FLUSH) ? 1'b0 : din;

    conv_enc_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .din     (enc_bit),
        .sr      (sr),
        .sym     (sym),
        .sr_next (sr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            flush_cnt  <= '0;
            sr         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else if (en) begin
            state      <= state_n;
            cnt        <= cnt_n;
            flush_cnt  <= flush_cnt_n;
            sr         <= sr_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
        end
    end

    // din_ready already folds in en; the register stage is en-gated, so din_valid suffices here.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        flush_cnt_n  = flush_cnt;
        sr_n         = sr;
        dout_n       = dout;
        dout_valid_n = dout_valid;
        frame_done_n = 1'b0;

        case (state)
            ST_IDLE: begin
                dout_valid_n = 1'b0;
                if (start) begin
                    sr_n        = '0;
                    cnt_n       = '0;
                    flush_cnt_n = '0;
                    state_n     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (din_valid) begin
                    dout_n       = sym;
                    dout_valid_n = 1'b1;
                    sr_n         = sr_next;
                    if (cnt == CNT_W'(FRAME_LEN - 1)) begin
                        cnt_n   = '0;
                        state_n = ST_FLUSH;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else begin
                    dout_valid_n = 1'b0;
                end
            end
            ST_FLUSH: begin
                dout_n       = sym;
                dout_valid_n = 1'b1;
                sr_n         = sr_next;
                if (flush_cnt == FL_W'(K - 2)) begin
                    flush_cnt_n = '0;
                    state_n     = ST_DONE;
                end else begin
                    flush_cnt_n = flush_cnt + FL_W'(1);
                end
            end
            ST_DONE: begin
                frame_done_n = 1'b1;
                dout_valid_n = 1'b0;
                state_n      = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_conv_enc_frame.sv
// Scoreboard bench for conv_enc_frame: directed frames with hand-computed symbols,
// plus a FRAME_LEN=1 instance.
module tb_conv_enc_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       start = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [1:0] dout;
    logic       dout_valid;
    logic       busy;
    logic       frame_done;

    logic       start1 = 1'b0;
    logic       din1 = 1'b0;
    logic       din_valid1 = 1'b0;
    logic       din_ready1;
    logic [1:0] dout1;
    logic       dout_valid1;
    logic       busy1;
    logic       frame_done1;

    conv_enc_frame #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(8)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .busy(busy),
        .frame_done(frame_done)
    );

    conv_enc_frame #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .start(start1), .din(din1), .din_valid(din_valid1),
        .din_ready(din_ready1), .dout(dout1), .dout_valid(dout_valid1), .busy(busy1),
        .frame_done(frame_done1)
    );

    always #5 clk = ~clk;

    // Symbols for 1,0,1,1,0,0,1,0 from the zero state, last two are the tail.
    localparam logic [1:0] EXP [10] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01,
                                        2'b11, 2'b11, 2'b10, 2'b11, 2'b00};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [1:0] q[$];
    logic [1:0] q1[$];
    int sym_cnt = 0, sym_cnt1 = 0;
    int frames_done = 0, frames_done1 = 0;
    int fd_cyc = 0, fd_cyc1 = 0;
    logic mon_en_q, mon_prev_dv = 1'b0, mon_en_q1, mon_prev_dv1 = 1'b0;
    logic [1:0] mon_e, mon_e1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        mon_en_q = en;
        #1;
        if (mon_en_q && !rst) begin
            if (dout_valid) begin
                sym_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sym_unexpected: got %b expected none", dout);
                end else begin
                    mon_e = q.pop_front();
                    chk("sym", int'(dout), int'(mon_e));
                end
            end
            if (frame_done) begin
                fd_cyc = cyc;
                frames_done++;
                chk("fd_after_last_sym", int'(mon_prev_dv), 1);
                chk("fd_queue_empty", q.size(), 0);
            end
            mon_prev_dv = dout_valid;
        end
    end

    always @(posedge clk) begin
        mon_en_q1 = en;
        #1;
        if (mon_en_q1 && !rst) begin
            if (dout_valid1) begin
                sym_cnt1++;
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sym1_unexpected: got %b expected none", dout1);
                end else begin
                    mon_e1 = q1.pop_front();
                    chk("sym1", int'(dout1), int'(mon_e1));
                end
            end
            if (frame_done1) begin
                fd_cyc1 = cyc;
                frames_done1++;
                chk("fd1_after_last_sym", int'(mon_prev_dv1), 1);
                chk("fd1_queue_empty", q1.size(), 0);
            end
            mon_prev_dv1 = dout_valid1;
        end
    end

    task automatic run_frame(input bit bubbles, input bit stall_data, input bit stall_flush,
                             input bit extras, input int abort_after, input bit timed);
        logic [7:0] bits;
        int acc, guard, c0, fd0, n;
        bit stalled, took;
        bits = 8'b10110010;
        acc = 0;
        guard = 0;
        stalled = 0;
        n = (abort_after > 0) ? abort_after : 10;
        for (int i = 0; i < n; i++) q.push_back(EXP[i]);
        sym_cnt = 0;
        fd0 = frames_done;

        if (extras) begin
            @(negedge clk);
            din_valid = 1'b1;
            din = 1'b1;
            repeat (3) @(negedge clk);
            chk("idle_din_ignored", sym_cnt, 0);
            chk("idle_not_busy", int'(busy), 0);
        end

        @(negedge clk);
        start = 1'b1;
        din_valid = extras;
        din = 1'b0;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        chk("busy_after_start", int'(busy), 1);
        chk("ready_after_start", int'(din_ready), 1);

        while (acc < 8 && guard < 100) begin
            if (stall_data && acc == 4 && !stalled) begin
                en = 1'b0;
                din_valid = 1'b1;
                din = bits[7-acc];
                repeat (3) @(negedge clk);
                chk("stall_data_dout", int'(dout), 1);
                chk("stall_data_dv", int'(dout_valid), 1);
                chk("stall_data_ready", int'(din_ready), 0);
                en = 1'b1;
                stalled = 1;
            end
            start = extras && (acc == 2);
            din_valid = !(bubbles && (guard % 2 == 1));
            din = bits[7-acc];
            #1;
            took = din_valid && din_ready;
            if (took) acc++;
            @(negedge clk);
            guard++;
            chk("dv_follows_accept", int'(dout_valid), int'(took));
            if (abort_after > 0 && acc == abort_after) begin
                rst = 1'b1;
                #1;
                chk("rst_dout", int'(dout), 0);
                chk("rst_dv", int'(dout_valid), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_fd", int'(frame_done), 0);
                chk("rst_ready", int'(din_ready), 0);
                chk("rst_syms", sym_cnt, abort_after);
                chk("rst_queue", q.size(), 0);
                @(negedge clk);
                rst = 1'b0;
                din_valid = 1'b0;
                start = 1'b0;
                repeat (6) @(negedge clk);
                chk("no_tail_after_rst", sym_cnt, abort_after);
                return;
            end
        end
        chk("data_accepts", acc, 8);
        din_valid = 1'b0;
        start = 1'b0;

        if (stall_flush) begin
            guard = 0;
            while (sym_cnt < 9 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            chk("flush_first_tail", sym_cnt, 9);
            en = 1'b0;
            repeat (3) @(negedge clk);
            chk("stall_flush_dout", int'(dout), 3);
            chk("stall_flush_dv", int'(dout_valid), 1);
            chk("stall_flush_busy", int'(busy), 1);
            chk("stall_flush_syms", sym_cnt, 9);
            en = 1'b1;
        end

        guard = 0;
        while (frames_done == fd0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("frame_done_seen", frames_done, fd0 + 1);
        chk("frame_syms", sym_cnt, 10);
        chk("busy_falls", int'(busy), 0);
        chk("ready_idle", int'(din_ready), 0);
        if (timed) chk("frame_edges", fd_cyc - c0, 11);
    endtask

    initial begin
        int guard, c0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_dout", int'(dout), 0);
        chk("reset_dv", int'(dout_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_fd", int'(frame_done), 0);
        chk("reset_ready", int'(din_ready), 0);
        chk("reset1_busy", int'(busy1), 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(0, 0, 0, 0, -1, 1);
        run_frame(1, 0, 0, 0, -1, 0);
        run_frame(0, 1, 1, 0, -1, 0);
        run_frame(0, 0, 0, 1, -1, 1);
        run_frame(0, 0, 0, 0, 4, 0);
        run_frame(0, 0, 0, 0, -1, 1);

        q1.push_back(2'b11);
        q1.push_back(2'b10);
        q1.push_back(2'b11);
        sym_cnt1 = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        c0 = cyc;
        din1 = 1'b1;
        din_valid1 = 1'b1;
        chk("len1_ready", int'(din_ready1), 1);
        @(negedge clk);
        din_valid1 = 1'b0;
        chk("len1_dv", int'(dout_valid1), 1);
        chk("len1_ready_after", int'(din_ready1), 0);
        guard = 0;
        while (frames_done1 == 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("len1_frame_done", frames_done1, 1);
        chk("len1_syms", sym_cnt1, 3);
        chk("len1_edges", fd_cyc1 - c0, 4);
        chk("len1_busy_falls", int'(busy1), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_enc_frame.md
# conv_enc_frame

Framed rate-1/2 convolutional encoder (constraint length K, generators G0/G1) that produces the coded symbol stream consumed by the Viterbi decoder datapath. It accepts one information bit per handshake, emits one 2-bit coded symbol per accepted bit, then appends K-1 zero tail bits so every frame terminates in state 0. Its global `en` stall matches the decoder controller's stall semantics, so encoder and decoder benches can share one enable source.

## Interface
- `K`, default 3: constraint length; shift register holds K-1 bits.
- `G0`, default 3'b111 (octal 7): generator for `dout[1]`; bit K-1 taps the current input.
- `G1`, default 3'b101 (octal 5): generator for `dout[0]`.
- `FRAME_LEN`, default 8: information bits per frame, ≥1.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `en` input 1: global enable; when low, all state, counters and outputs hold.
- `start` input 1: begin a frame; honoured only in IDLE with `en`=1.
- `din` input 1: information bit.
- `din_valid` input 1: `din` is valid.
- `din_ready` output 1: encoder accepts `din`. Combinational: high iff state=DATA and `en`=1.
- `dout` output 2: coded symbol {G0 parity, G1 parity}, registered.
- `dout_valid` output 1: `dout` valid this cycle, registered.
- `busy` output 1: state ≠ IDLE, registered.
- `frame_done` output 1: one-cycle pulse after the last tail symbol, registered.

## Operation
- States: IDLE, DATA, FLUSH, DONE.
- Global rule: every state, counter and registered-output update requires `en`=1. With `en`=0 all of them hold their current values; `dout_valid` and `frame_done` are held, not cleared.
- IDLE:
  - On `start`: clear the shift register `sr` and `cnt`, then go to DATA.
  - `din_valid` is ignored.
- DATA:
  - An accepted bit is one where `din_valid`&&`din_ready`.
  - For each accepted bit, form `v` = {`din`, `sr`} (K bits).
  - `dout[1]` <= ^(`v`&G0); `dout[0]` <= ^(`v`&G1); `dout_valid` <= 1.
  - Then `sr` <= {`din`, `sr`[K-2:1]} and `cnt`++.
  - When the accepted bit makes `cnt` reach FRAME_LEN: clear `cnt` and go to FLUSH.
  - No accept in a cycle: `dout_valid` <= 0. Bubbles are allowed.
- FLUSH:
  - Encode `din`=0 every cycle, without handshake; `dout_valid` <= 1.
  - After K-1 cycles, go to DONE.
- DONE:
  - `frame_done` <= 1, `dout_valid` <= 0, then go to IDLE.
  - `frame_done` is 0 in all other states.
- Arithmetic:
  - Parities are XOR reductions.
  - `cnt` width is $clog2(FRAME_LEN+1); `cnt` never wraps past FRAME_LEN.
- Boundary cases:
  - `start` while `busy` is ignored.
  - `start` and `din_valid` in the same IDLE cycle: the frame starts, and that `din` is not consumed.
  - FRAME_LEN=1: DATA lasts exactly one accept.
  - `rst` mid-frame: immediate return to IDLE, `sr`=0, `cnt`=0, all outputs 0; no partial tail is emitted.
  - `en` dropping mid-FLUSH pauses the tail; it resumes on `en`=1 with the correct remaining count.
- Reset values: `dout`=2'b00, `dout_valid`=0, `busy`=0, `frame_done`=0. `din_ready`=0 follows from state=IDLE.

## Timing
- Symbol latency: an accept at edge t gives `dout`/`dout_valid` during cycle t+1.
- `start` sampled at edge t: `busy`=1 and `din_ready`=1 from cycle t+1.
- Best-case frame:
  - 1 start cycle.
  - FRAME_LEN data cycles.
  - K-1 flush cycles.
  - 1 DONE cycle.
  - Total FRAME_LEN+K+1 edges from `start` to IDLE.
- Exactly FRAME_LEN+K-1 `dout_valid` cycles per frame.
- `frame_done` is asserted in the cycle directly after the last valid symbol.
- Back-to-back frames: `start` may be asserted in the cycle IDLE is re-entered.

## Structure
- Shared package `viterbi_pkg`:
  - K, G0, G1 defaults, so the decoder branch-metric unit uses identical generators.
  - The encoder state enum.
  - A `parity(v,g)` function.
- One sub-module: `conv_enc_core`. It holds the combinational symbol generation from `din`, `sr`, G0 and G1, plus the `sr` update. The FSM and counters stay in the top.

## Test plan
- Reset, then `start`; feed 1,0,1,1,0,0,1,0 continuously with `en`=1 -> `dout` = 11,10,00,01,01,11,11,10,11,00 (last two are tail), then `frame_done` pulse, `busy` falls.
- Same frame with `din_valid` low every other cycle -> same 10 symbols, with `dout_valid` gaps aligned to the bubbles.
- `en` low for 3 cycles mid-DATA and mid-FLUSH -> outputs frozen during the stall, final symbol sequence unchanged.
- `start` pulsed while `busy`, and `din_valid` in IDLE -> both ignored; symbol count stays exactly 10.
- `rst` asserted after 4 accepted bits -> outputs zero immediately; a new frame encodes as from the all-zero state.
- FRAME_LEN=1, `din`=1 -> symbols 11,10,11, then `frame_done`.
